// File: rtl/scale_saturate_pipe.sv
// rtl/scale_saturate_pipe.sv - pipelined tilt-to-pixel scale, offset and signed clamp
// Three stages: saturating invert, gain plus centre offset, clamp with edge-hit tracking.
module scale_saturate_pipe #(
  parameter int IN_W     = 16,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int MARGIN_X = 8,
  parameter int MARGIN_Y = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_x,
  input  logic signed [IN_W-1:0] in_y,
  input  logic [1:0]             gain_sel,
  input  logic                   invert_x,
  input  logic                   invert_y,
  input  logic                   clr_hits,
  output logic                   out_valid,
  output logic [X_W-1:0]         pixel_x,
  output logic [Y_W-1:0]         pixel_y,
  output logic                   sat_x_lo,
  output logic                   sat_x_hi,
  output logic                   sat_y_lo,
  output logic                   sat_y_hi,
  output logic                   edge_pulse,
  output logic [7:0]             hit_count
);

  localparam int S_W = IN_W + 3;

  localparam logic signed [S_W-1:0] XLO  = S_W'(MARGIN_X);
  localparam logic signed [S_W-1:0] XHI  = S_W'(SCREEN_W - 1 - MARGIN_X);
  localparam logic signed [S_W-1:0] YLO  = S_W'(MARGIN_Y);
  localparam logic signed [S_W-1:0] YHI  = S_W'(SCREEN_H - 1 - MARGIN_Y);
  localparam logic signed [S_W-1:0] XOFF = S_W'(SCREEN_W / 2);
  localparam logic signed [S_W-1:0] YOFF = S_W'(SCREEN_H / 2);

  localparam logic [X_W-1:0] XLO_N = X_W'(MARGIN_X);
  localparam logic [X_W-1:0] XHI_N = X_W'(SCREEN_W - 1 - MARGIN_X);
  localparam logic [Y_W-1:0] YLO_N = Y_W'(MARGIN_Y);
  localparam logic [Y_W-1:0] YHI_N = Y_W'(SCREEN_H - 1 - MARGIN_Y);
  localparam logic [X_W-1:0] XCTR  = X_W'(SCREEN_W / 2);
  localparam logic [Y_W-1:0] YCTR  = Y_W'(SCREEN_H / 2);

  // The most negative input has no positive twin, so it pins to the most positive value.
  function automatic logic signed [IN_W-1:0] sat_neg(input logic signed [IN_W-1:0] v);
    if (v == {1'b1, {(IN_W-1){1'b0}}})
      return {1'b0, {(IN_W-1){1'b1}}};
    else
      return -v;
  endfunction

  function automatic logic signed [S_W-1:0] apply_gain(input logic signed [IN_W-1:0] v,
                                                      input logic [1:0] g);
    logic signed [S_W-1:0] e;
    e = {{3{v[IN_W-1]}}, v};
    case (g)
      2'd0:    return e;
      2'd1:    return e <<< 1;
      2'd2:    return e >>> 1;
      default: return e >>> 2;
    endcase
  endfunction

  logic                   v1, v2;
  logic signed [IN_W-1:0] s1_x, s1_y;
  logic [1:0]             s1_gain;
  logic signed [S_W-1:0]  s2_x, s2_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_gain <= '0;
      s2_x    <= '0;
      s2_y    <= '0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      if (in_valid) begin
        s1_x    <= invert_x ? sat_neg(in_x) : in_x;
        s1_y    <= invert_y ? sat_neg(in_y) : in_y;
        s1_gain <= gain_sel;
      end
      if (v1) begin
        s2_x <= apply_gain(s1_x, s1_gain) + XOFF;
        s2_y <= apply_gain(s1_y, s1_gain) + YOFF;
      end
    end
  end

  logic           x_lo_n, x_hi_n, y_lo_n, y_hi_n;
  logic [X_W-1:0] px_n;
  logic [Y_W-1:0] py_n;
  logic           pulse_n;

  always_comb begin
    x_lo_n  = (s2_x < XLO);
    x_hi_n  = (s2_x > XHI);
    y_lo_n  = (s2_y < YLO);
    y_hi_n  = (s2_y > YHI);
    px_n    = x_lo_n ? XLO_N : (x_hi_n ? XHI_N : s2_x[X_W-1:0]);
    py_n    = y_lo_n ? YLO_N : (y_hi_n ? YHI_N : s2_y[Y_W-1:0]);
    pulse_n = v2 & |({x_lo_n, x_hi_n, y_lo_n, y_hi_n} &
                     ~{sat_x_lo, sat_x_hi, sat_y_lo, sat_y_hi});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pixel_x    <= XCTR;
      pixel_y    <= YCTR;
      sat_x_lo   <= 1'b0;
      sat_x_hi   <= 1'b0;
      sat_y_lo   <= 1'b0;
      sat_y_hi   <= 1'b0;
      edge_pulse <= 1'b0;
      hit_count  <= 8'd0;
    end else begin
      out_valid  <= v2;
      edge_pulse <= pulse_n;
      if (v2) begin
        pixel_x  <= px_n;
        pixel_y  <= py_n;
        sat_x_lo <= x_lo_n;
        sat_x_hi <= x_hi_n;
        sat_y_lo <= y_lo_n;
        sat_y_hi <= y_hi_n;
      end
      // Counter moves on the same edge that raises edge_pulse; clear wins over a hit.
      if (clr_hits)
        hit_count <= 8'd0;
      else if (pulse_n && hit_count != 8'hFF)
        hit_count <= hit_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_scale_saturate_pipe.sv
// tb/tb_scale_saturate_pipe.sv - directed self-checking bench for scale_saturate_pipe
module tb_scale_saturate_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_x = '0;
  logic signed [15:0] in_y = '0;
  logic [1:0]         gain_sel = '0;
  logic               invert_x = 1'b0;
  logic               invert_y = 1'b0;
  logic               clr_hits = 1'b0;
  logic               out_valid;
  logic [9:0]         pixel_x;
  logic [8:0]         pixel_y;
  logic               sat_x_lo, sat_x_hi, sat_y_lo, sat_y_hi;
  logic               edge_pulse;
  logic [7:0]         hit_count;

  int n_tests = 0;
  int n_fail  = 0;

  scale_saturate_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .gain_sel(gain_sel), .invert_x(invert_x), .invert_y(invert_y), .clr_hits(clr_hits),
    .out_valid(out_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sat_x_lo(sat_x_lo), .sat_x_hi(sat_x_hi), .sat_y_lo(sat_y_lo), .sat_y_hi(sat_y_hi),
    .edge_pulse(edge_pulse), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int g, input bit ix, input bit iy);
    in_valid = 1'b1;
    in_x     = 16'(x);
    in_y     = 16'(y);
    gain_sel = 2'(g);
    invert_x = ix;
    invert_y = iy;
  endtask

  // Called at a falling edge; returns at the falling edge where the result is visible.
  task automatic run_one(input int x, input int y, input int g, input bit ix, input bit iy);
    drive(x, y, g, ix, iy);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat2_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat3_valid", 32'(out_valid), 1);
  endtask

  task automatic check_out(input string tag, input int px, input int py, input logic [3:0] flags,
                           input bit ep, input int hc);
    check({tag, "_px"}, 32'(pixel_x), 32'(px));
    check({tag, "_py"}, 32'(pixel_y), 32'(py));
    check({tag, "_flags"}, 32'({sat_x_lo, sat_x_hi, sat_y_lo, sat_y_hi}), 32'(flags));
    check({tag, "_pulse"}, 32'(edge_pulse), 32'(ep));
    check({tag, "_hits"}, 32'(hit_count), 32'(hc));
  endtask

  int seen;
  int first_cyc, last_cyc;
  int got_px[$];

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check_out("rst", 320, 240, 4'b0000, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // flags order: {x_lo, x_hi, y_lo, y_hi}
    run_one(0, 0, 0, 0, 0);
    check_out("centre", 320, 240, 4'b0000, 1'b0, 0);
    @(negedge clk);
    check("centre_one_cycle", 32'(out_valid), 0);

    run_one(400, -300, 0, 0, 0);
    check_out("sat1", 631, 8, 4'b0110, 1'b1, 1);
    run_one(400, -300, 0, 0, 0);
    check_out("sat_repeat", 631, 8, 4'b0110, 1'b0, 1);

    run_one(0, -32768, 0, 0, 0);
    check_out("ymin", 320, 8, 4'b0010, 1'b0, 1);
    run_one(0, -32768, 0, 0, 1);
    check_out("ymin_inv", 320, 471, 4'b0001, 1'b1, 2);
    run_one(32767, 0, 1, 0, 0);
    check_out("xmax_x2", 631, 240, 4'b0100, 1'b1, 3);

    run_one(100, 0, 1, 0, 0);
    check_out("g_x2", 520, 240, 4'b0000, 1'b0, 3);
    run_one(100, 0, 3, 0, 0);
    check_out("g_d4", 345, 240, 4'b0000, 1'b0, 3);
    run_one(-7, 0, 3, 0, 0);
    check_out("neg_d4", 318, 240, 4'b0000, 1'b0, 3);
    run_one(-7, 0, 2, 0, 0);
    check_out("neg_d2", 316, 240, 4'b0000, 1'b0, 3);

    // Back-to-back stream; gain and invert alternate per sample.
    seen = 0; first_cyc = -1; last_cyc = -1;
    got_px.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          drive(i * 10 + 5, 0, (i % 2 == 0) ? 1 : 0, (i % 2 == 1), 1'b0);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid) begin
            seen++;
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            got_px.push_back(int'(pixel_x));
          end
        end
      end
    join
    check("stream_count", 32'(seen), 10);
    check("stream_contig", 32'(last_cyc - first_cyc), 9);
    for (int i = 0; i < 10; i++) begin
      int e;
      e = (i % 2 == 0) ? 320 + 2 * (i * 10 + 5) : 320 - (i * 10 + 5);
      check($sformatf("stream_px%0d", i), (i < got_px.size()) ? 32'(got_px[i]) : 32'hFFFF_FFFF,
            32'(e));
    end

    // Reset with two samples still in the pipe.
    drive(400, 0, 0, 0, 0);
    @(negedge clk);
    drive(400, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_valids", 32'(seen), 0);
    check_out("flush", 320, 240, 4'b0000, 1'b0, 0);

    // 300 edge events interleaved with centre samples.
    for (int i = 0; i < 600; i++) begin
      drive((i % 2 == 1) ? 400 : 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("hits_sat", 32'(hit_count), 255);

    run_one(0, 0, 0, 0, 0);
    check_out("pre_clr", 320, 240, 4'b0000, 1'b0, 255);

    // Clear lands on the same edge that raises the pulse.
    drive(400, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr_hits = 1'b1;
    @(negedge clk);
    clr_hits = 1'b0;
    check("clr_valid", 32'(out_valid), 1);
    check_out("clr_coinc", 631, 240, 4'b0100, 1'b1, 0);

    run_one(0, 0, 0, 0, 0);
    run_one(400, 0, 0, 0, 0);
    check_out("after_clr", 631, 240, 4'b0100, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
